// File: rtl/game_controller.sv
// game_controller -- top-level sequencer for the whack-a-mole game.
//
// Runs the IDLE -> LOAD -> START -> DONE game flow, drives the scoreboard
// clear/trigger inputs from player hit pulses and keeps a BCD countdown of
// the seconds left in the round.
//
// Optional feature macro: SCORE_SAT_EN
//   defined   : a 10-bit hit counter suppresses triggers once 999 have been
//               issued in the current round, so the scoreboard saturates.
//   undefined : every hit taken in START produces a trigger.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   start_btn     in   debounced start button level (acted on at rising edge)
//   hit           in   one-cycle pulse per mole hit
//   global_state  out  IDLE=00 LOAD=01 START=10 DONE=11 (FSM state register)
//   score_clear   out  high for the whole of LOAD
//   score_trigger out  one-cycle pulse, hit delayed by one cycle, START only
//   time_tens     out  BCD tens of seconds remaining
//   time_ones     out  BCD ones of seconds remaining
//   game_over     out  high while in DONE
//
// Handshake note: there is no valid/ready flow here; hit and score_trigger
// are single-cycle strobes with no back-pressure, and a strobe is consumed
// on the clock edge where it is sampled high.
module game_controller #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int GAME_SECONDS  = 30,
  parameter int LOAD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       hit,
  output logic [1:0] global_state,
  output logic       score_clear,
  output logic       score_trigger,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       game_over
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [LW-1:0] LOAD_MAX  = LW'(LOAD_CYCLES - 1);
  localparam logic [3:0]    INIT_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]    INIT_ONES = 4'(GAME_SECONDS % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    START = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state, next_state;
  logic          start_btn_q;
  logic          start_edge;
  logic [LW-1:0] load_cnt;
  logic [PW-1:0] presc;
  logic          load_done;
  logic          sec_wrap;
  logic          last_sec;
  logic          issue;

  assign start_edge = start_btn & ~start_btn_q;
  assign load_done  = (load_cnt == LOAD_MAX);
  assign sec_wrap   = (presc == PRESC_MAX);
  assign last_sec   = (time_tens == 4'd0) && (time_ones == 4'd1);

  // Cleared in reset so a button held through reset release counts as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_btn_q <= 1'b0;
    else     start_btn_q <= start_btn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge) next_state = LOAD;
      LOAD:    if (load_done) next_state = START;
      START:   if (sec_wrap && last_sec) next_state = DONE;
      DONE:    if (start_edge) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Load counter, prescaler and BCD countdown. The prescaler is held at zero
  // outside START so the first second is a full TICKS_PER_SEC cycles long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= '0;
      presc     <= '0;
      time_tens <= INIT_TENS;
      time_ones <= INIT_ONES;
    end else begin
      case (state)
        LOAD: begin
          load_cnt  <= load_done ? '0 : load_cnt + 1'b1;
          presc     <= '0;
          time_tens <= INIT_TENS;
          time_ones <= INIT_ONES;
        end
        START: begin
          load_cnt <= '0;
          if (sec_wrap) begin
            presc <= '0;
            if (time_ones == 4'd0) begin
              time_ones <= 4'd9;
              time_tens <= time_tens - 4'd1;
            end else begin
              time_ones <= time_ones - 4'd1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          load_cnt <= '0;
          presc    <= '0;
        end
      endcase
    end
  end

`ifdef SCORE_SAT_EN
  logic [9:0] hit_cnt;

  // Stop issuing once 999 triggers went out this round.
  assign issue = hit && (state == START) && (hit_cnt != 10'd999);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 hit_cnt <= '0;
    else if (state == LOAD)  hit_cnt <= '0;
    else if (issue)          hit_cnt <= hit_cnt + 10'd1;
  end
`else
  assign issue = hit && (state == START);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_trigger <= 1'b0;
    else     score_trigger <= issue;
  end

  assign global_state = state;
  assign score_clear  = (state == LOAD);
  assign game_over    = (state == DONE);

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

  logic       clk;
  logic       rst, start_btn, hit;
  logic [1:0] global_state;
  logic       score_clear, score_trigger, game_over;
  logic [3:0] time_tens, time_ones;

  logic       rst2, start2, hit2;
  logic [1:0] state2;
  logic       clear2, trig2, over2;
  logic [3:0] tens2, ones2;

  int total = 0;
  int bad   = 0;

  game_controller #(.TICKS_PER_SEC(4), .GAME_SECONDS(12), .LOAD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .hit(hit),
    .global_state(global_state), .score_clear(score_clear),
    .score_trigger(score_trigger), .time_tens(time_tens),
    .time_ones(time_ones), .game_over(game_over)
  );

  // Long seconds so 1005 hits fit inside a single-second round.
  game_controller #(.TICKS_PER_SEC(1100), .GAME_SECONDS(1), .LOAD_CYCLES(3)) dut_sat (
    .clk(clk), .rst(rst2), .start_btn(start2), .hit(hit2),
    .global_state(state2), .score_clear(clear2),
    .score_trigger(trig2), .time_tens(tens2),
    .time_ones(ones2), .game_over(over2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b0; hit = 1'b0;
    tick(); tick();
    total++;
    if (global_state !== 2'b00 || time_tens !== 4'd1 || time_ones !== 4'd2) begin
      bad++;
      $display("FAIL reset_state: state=%b time=%0d%0d expected state=00 time=12",
               global_state, time_tens, time_ones);
    end
    total++;
    if (score_clear !== 1'b0 || score_trigger !== 1'b0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: clear=%b trig=%b over=%b expected 0 0 0",
               score_clear, score_trigger, game_over);
    end
    rst = 1'b0;
    // Hit in IDLE must be dropped.
    hit = 1'b1;
    tick();
    hit = 1'b0;
    total++;
    if (score_trigger !== 1'b0) begin
      bad++;
      $display("FAIL idle_hit: trig=%b expected 0", score_trigger);
    end
    repeat (4) tick();
    total++;
    if (global_state !== 2'b00) begin
      bad++;
      $display("FAIL idle_hold: state=%b expected 00", global_state);
    end
  endtask

  task automatic test_start_load();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    // First LOAD cycle: a hit here must be dropped.
    hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (global_state !== 2'b01 || score_clear !== 1'b1) begin
        bad++;
        $display("FAIL load_cycle%0d: state=%b clear=%b expected 01 1",
                 i, global_state, score_clear);
      end
      tick();
      hit = 1'b0;
      if (i == 0) begin
        total++;
        if (score_trigger !== 1'b0) begin
          bad++;
          $display("FAIL load_hit: trig=%b expected 0", score_trigger);
        end
      end
    end
    total++;
    if (global_state !== 2'b10 || score_clear !== 1'b0) begin
      bad++;
      $display("FAIL start_entry: state=%b clear=%b expected 10 0",
               global_state, score_clear);
    end
  endtask

  // Called at START entry; runs the whole round with no hits.
  task automatic test_countdown();
    int sec;
    for (int k = 1; k <= 48; k++) begin
      tick();
      sec = 12 - k / 4;
      if (k % 4 == 0 || k == 1) begin
        total++;
        if (time_tens !== 4'(sec / 10) || time_ones !== 4'(sec % 10)) begin
          bad++;
          $display("FAIL countdown_k%0d: time=%0d%0d expected %0d%0d",
                   k, time_tens, time_ones, sec / 10, sec % 10);
        end
      end
      if (k == 47) begin
        total++;
        if (global_state !== 2'b10 || game_over !== 1'b0) begin
          bad++;
          $display("FAIL pre_done: state=%b over=%b expected 10 0", global_state, game_over);
        end
      end
    end
    total++;
    if (global_state !== 2'b11 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL done_at_48: state=%b over=%b expected 11 1", global_state, game_over);
    end
    repeat (3) tick();
    total++;
    if (time_tens !== 4'd0 || time_ones !== 4'd0 || global_state !== 2'b11) begin
      bad++;
      $display("FAIL done_hold: state=%b time=%0d%0d expected 11 00",
               global_state, time_tens, time_ones);
    end
  endtask

  // From DONE: drop a hit, replay, 3 back-to-back hits, ignored mid-round
  // start, hit on the final decrement.
  task automatic test_hits_replay();
    int k;
    hit = 1'b1;
    tick();
    hit = 1'b0;
    total++;
    if (score_trigger !== 1'b0) begin
      bad++;
      $display("FAIL done_hit: trig=%b expected 0", score_trigger);
    end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    total++;
    if (global_state !== 2'b01 || score_clear !== 1'b1 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL replay_load: state=%b clear=%b over=%b expected 01 1 0",
               global_state, score_clear, game_over);
    end
    repeat (3) tick();
    total++;
    if (global_state !== 2'b10 || time_tens !== 4'd1 || time_ones !== 4'd2) begin
      bad++;
      $display("FAIL replay_reload: state=%b time=%0d%0d expected 10 12",
               global_state, time_tens, time_ones);
    end
    // k counts edges since START entry.
    hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (score_trigger !== 1'b1) begin
        bad++;
        $display("FAIL burst_trig%0d: trig=%b expected 1", i, score_trigger);
      end
    end
    hit = 1'b0;
    tick();
    total++;
    if (score_trigger !== 1'b0) begin
      bad++;
      $display("FAIL burst_end: trig=%b expected 0", score_trigger);
    end
    k = 4;
    start_btn = 1'b1;
    tick(); k++;
    start_btn = 1'b0;
    total++;
    if (global_state !== 2'b10 || score_clear !== 1'b0) begin
      bad++;
      $display("FAIL midround_start: state=%b clear=%b expected 10 0",
               global_state, score_clear);
    end
    while (k < 47) begin
      tick(); k++;
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    total++;
    if (score_trigger !== 1'b1 || global_state !== 2'b11 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL final_hit: trig=%b state=%b over=%b expected 1 11 1",
               score_trigger, global_state, game_over);
    end
    tick();
    total++;
    if (score_trigger !== 1'b0) begin
      bad++;
      $display("FAIL final_hit_end: trig=%b expected 0", score_trigger);
    end
  endtask

  task automatic test_async_reset();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    repeat (3) tick();
    repeat (5) tick();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    total++;
    if (score_trigger !== 1'b1 || global_state !== 2'b10) begin
      bad++;
      $display("FAIL pre_reset: trig=%b state=%b expected 1 10", score_trigger, global_state);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (global_state !== 2'b00 || score_trigger !== 1'b0 || time_tens !== 4'd1 ||
        time_ones !== 4'd2) begin
      bad++;
      $display("FAIL async_reset: state=%b trig=%b time=%0d%0d expected 00 0 12",
               global_state, score_trigger, time_tens, time_ones);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int trig_cnt;
    int exp_cnt;
`ifdef SCORE_SAT_EN
    exp_cnt = 999;
`else
    exp_cnt = 1005;
`endif
    trig_cnt = 0;
    rst2 = 1'b1; start2 = 1'b0; hit2 = 1'b0;
    tick();
    rst2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (3) tick();
    total++;
    if (state2 !== 2'b10) begin
      bad++;
      $display("FAIL sat_start: state=%b expected 10", state2);
    end
    hit2 = 1'b1;
    for (int i = 0; i < 1005; i++) begin
      tick();
      if (trig2 === 1'b1) trig_cnt++;
    end
    hit2 = 1'b0;
    tick();
    if (trig2 === 1'b1) trig_cnt++;
    total++;
    if (trig_cnt != exp_cnt) begin
      bad++;
      $display("FAIL sat_count: triggers=%0d expected %0d", trig_cnt, exp_cnt);
    end
  endtask

  initial begin
    rst2 = 1'b1; start2 = 1'b0; hit2 = 1'b0;
    test_reset();
    test_start_load();
    test_countdown();
    test_hits_replay();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
